// File: rtl/serial_chunk_adder_if.sv
// Handshake and operand/result bundle for serial_chunk_adder.
// The master drives the request and operands; the slave returns status and results.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, s, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, s, cout, ovf, zero
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor that adds CHUNK bits per clock over WIDTH/CHUNK cycles.
// Define SCA_SATURATE_EN to clamp signed overflow to the most positive/negative value.
module serial_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_chunk_adder_if.slave  bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((WIDTH % CHUNK) != 0) begin : g_cfg_err
    $error("serial_chunk_adder: WIDTH must be an integer multiple of CHUNK");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Operands are shifted right each RUN cycle, so the active chunk is always the low slice.
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;
  logic             res_ovf;
  logic [WIDTH-1:0] s_shift;
  logic [WIDTH-1:0] s_final;

  assign a_chunk   = a_q[CHUNK-1:0];
  assign b_chunk   = b_q[CHUNK-1:0];
  assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  assign msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
  assign res_ovf   = msb_cin ^ chunk_sum[CHUNK];
  assign s_shift   = (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK)) | (s_q >> CHUNK);

`ifdef SCA_SATURATE_EN
  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  assign s_final = res_ovf ? ((a_chunk[CHUNK-1] | b_chunk[CHUNK-1]) ? S_MIN : S_MAX) : s_shift;
`else
  assign s_final = s_shift;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        s_d     = s_shift;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          s_d     = s_final;
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = res_ovf;
          zero_d  = (s_final == '0);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // NOTE: operand registers need no reset; they are always loaded on start before being read.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed, scoreboard-based bench for serial_chunk_adder (32/8 and 16/4 instances).
// Expected results come from a full-width reference add computed when each start is driven.
module tb_serial_chunk_adder;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int N  = W / C;
  localparam int W2 = 16;
  localparam int C2 = 4;
  localparam int N2 = W2 / C2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_chunk_adder_if #(.WIDTH(W))  bus  ();
  serial_chunk_adder_if #(.WIDTH(W2)) bus2 ();

  serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_chunk_adder #(.WIDTH(W2), .CHUNK(C2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t         r;
    logic [W-1:0] be;
    logic [W:0]   full;
    be     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, sub};
    r.s    = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == be[W-1]) && (r.s[W-1] != a[W-1]);
`ifdef SCA_SATURATE_EN
    if (r.ovf) r.s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    r.zero = (r.s == '0);
    return r;
  endfunction

  // Start in cycle 0, scramble operands and retry start while busy/done, then score the result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input string tag);
    res_t exp;
    int   cyc;
    int   busy_bad;
    sb_q.push_back(model(a, b, sub));
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    cyc       = 0;
    busy_bad  = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == 2) || (cyc == N + 1);
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.sub   = ~sub;
      if (cyc <= N && bus.busy !== 1'b1) busy_bad++;
      if (cyc <= N && bus.done !== 1'b0) busy_bad++;
    end while (bus.done !== 1'b1 && cyc < 20);
    check({tag, "_latency"}, 64'(cyc), 64'(N + 1));
    check({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      check({tag, "_s"},    64'(bus.s),    64'(exp.s));
      check({tag, "_cout"}, 64'(bus.cout), 64'(exp.cout));
      check({tag, "_ovf"},  64'(bus.ovf),  64'(exp.ovf));
      check({tag, "_zero"}, 64'(bus.zero), 64'(exp.zero));
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      check({tag, "_no_restart"}, 64'(bus.busy), 64'd0);
      check({tag, "_s_hold"},     64'(bus.s),    64'(exp.s));
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int done_seen;
    int cyc;

    bus.start  = 1'b1;
    bus.sub    = 1'b0;
    bus.a      = 32'd84;
    bus.b      = 32'd35;
    bus2.start = 1'b0;
    bus2.sub   = 1'b0;
    bus2.a     = '0;
    bus2.b     = '0;
    rst        = 1'b1;

    // Reset with start held high: everything cleared and start ignored.
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_s",    64'(bus.s),    64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_ovf",  64'(bus.ovf),  64'd0);
    check("rst_zero", 64'(bus.zero), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'(bus.busy), 64'd0);

    run_op(32'd84,        32'd35, 1'b0, "add_84_35");
    run_op(32'd55,        32'd68, 1'b1, "sub_55_68");
    run_op(32'h7FFF_FFFF, 32'd1,  1'b0, "pos_ovf");
    run_op(32'hFFFF_FFFF, 32'd1,  1'b0, "wrap_zero");
    run_op(32'h8000_0000, 32'd1,  1'b1, "neg_ovf");
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, "sub_equal");
    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(1)), $sformatf("rand%0d", i));
    end

    // Mid-run reset: start in cycle 0, extra start in cycle 2, rst in cycle 3.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd84;
    bus.b     = 32'd35;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_s",    64'(bus.s),    64'd0);
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    // Narrow instance: 16-bit operands, 4-bit chunks.
    @(negedge clk);
    bus2.start = 1'b1;
    bus2.a     = 16'h1234;
    bus2.b     = 16'h0FFF;
    bus2.sub   = 1'b0;
    cyc        = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus2.start = 1'b0;
      bus2.a     = '0;
      bus2.b     = '0;
    end while (bus2.done !== 1'b1 && cyc < 20);
    check("w16_latency", 64'(cyc),       64'(N2 + 1));
    check("w16_s",       64'(bus2.s),    64'h2233);
    check("w16_cout",    64'(bus2.cout), 64'd0);
    check("w16_ovf",     64'(bus2.ovf),  64'd0);
    check("w16_zero",    64'(bus2.zero), 64'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
